// File: rtl/sram_bist.sv
// sram_bist -- march-style write-then-read self test for an external SRAM
// reached through a simple request/acknowledge controller port.
//
// The test writes P(a) to every address 0..LAST_ADDR, then reads each
// address back and compares it with P(a). The pattern is
//   P(a) = a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ seed
// and address bits above ADDR_W count as zero. Mismatches are counted,
// saturating at 16'hFFFF, and the first failing address is captured.
// A request that waits TIMEOUT cycles without an acknowledge aborts the test.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle start pulse; ignored while o_busy=1
//   i_seed       pattern seed, sampled when a start is accepted
//   o_req        transaction request to the SRAM controller
//   o_we         1 = write, 0 = read; valid while o_req=1
//   o_addr       transaction address
//   o_wdata      write data
//   i_ack        controller completion strobe
//   i_rdata      read data, valid only in the i_ack cycle of a read
//   o_busy       test in progress (WRITE or READ)
//   o_done       test finished; held until the next accepted start
//   o_pass       valid with o_done: no mismatches and no timeout
//   o_timeout    test aborted by an acknowledge timeout
//   o_err_cnt    mismatch count (saturating)
//   o_fail_addr  address of the first mismatch
//   o_led        on when passed, blinking while busy, off otherwise
//   dbg_state    current FSM state (IDLE=0, WRITE=1, READ=2, DONE=3)
//
// Handshake: o_req/o_we/o_addr/o_wdata come straight from registers and do
// not change while o_req=1. A transaction completes in the cycle where
// o_req=1 and i_ack=1. The next cycle always has o_req=0 (gap), and the
// following transaction raises o_req one cycle later. i_ack seen while
// o_req=0 has no effect.

module sram_bist #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned LAST_ADDR = 2**ADDR_W - 1,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_seed,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    input  logic              i_ack,
    input  logic [7:0]        i_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [15:0]       o_err_cnt,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic              o_led,
    output logic [1:0]        dbg_state
);

    // The wait counter only has to reach TIMEOUT-1: the abort fires on the
    // TIMEOUT-th unacknowledged request cycle.
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(LAST_ADDR);
    localparam int unsigned LED_W = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          seed_q, seed_d;
    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   fail_q, fail_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [LED_W-1:0]    led_cnt_q, led_cnt_d;
    logic                led_q, led_d;

    function automatic logic [7:0] pattern(input logic [ADDR_W-1:0] a,
                                           input logic [7:0]        s);
        logic [19:0] x;
        x = 20'(a);  // zero-extends narrow address buses
        return x[7:0] ^ x[15:8] ^ {4'h0, x[19:16]} ^ s;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        seed_d    = seed_q;
        err_d     = err_q;
        fail_d    = fail_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        wait_d    = wait_q;
        led_cnt_d = led_cnt_q;
        led_d     = led_q;

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d   = WRITE;
                    req_d     = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = '0;
                    wdata_d   = pattern('0, i_seed);
                    seed_d    = i_seed;
                    err_d     = '0;
                    fail_d    = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    wait_d    = '0;
                    led_cnt_d = '0;
                    led_d     = 1'b0;
                end
            end

            WRITE, READ: begin
                led_cnt_d = led_cnt_q + LED_W'(1);
                if (&led_cnt_q) begin
                    led_d = ~led_q;
                end

                if (req_q) begin
                    if (i_ack) begin
                        // Completion: drop the request for the gap cycle.
                        req_d = 1'b0;
                        if (state_q == READ && i_rdata != pattern(addr_q, seed_q)) begin
                            if (err_q != 16'hFFFF) begin
                                err_d = err_q + 16'd1;
                            end
                            if (err_q == 16'd0) begin
                                fail_d = addr_q;
                            end
                        end
                        if (addr_q == LAST) begin
                            if (state_q == WRITE) begin
                                state_d = READ;
                                addr_d  = '0;
                            end else begin
                                state_d = DONE;
                                we_d    = 1'b0;
                                done_d  = 1'b1;
                                pass_d  = (err_d == 16'd0);
                            end
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_d   = DONE;
                        req_d     = 1'b0;
                        we_d      = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    // Gap cycle: set up the next transaction for the
                    // already-advanced address and restart the wait count.
                    req_d   = 1'b1;
                    we_d    = (state_q == WRITE);
                    wdata_d = pattern(addr_q, seed_q);
                    wait_d  = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            seed_q    <= '0;
            err_q     <= '0;
            fail_q    <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
            led_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
            led_cnt_q <= led_cnt_d;
            led_q     <= led_d;
        end
    end

    assign o_req       = req_q;
    assign o_we        = we_q;
    assign o_addr      = addr_q;
    assign o_wdata     = wdata_q;
    assign o_busy      = (state_q == WRITE) || (state_q == READ);
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_timeout   = timeout_q;
    assign o_err_cnt   = err_q;
    assign o_fail_addr = fail_q;
    assign o_led       = (state_q == DONE) ? pass_q : (o_busy ? led_q : 1'b0);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: a 16-address instance (TIMEOUT=8) driven by an SRAM
// model with configurable ack delay, read corruption, hung address and
// stray acks, checked every cycle against a transaction-queue model; plus a
// single-address instance (LAST_ADDR=0).

module tb_sram_bist;

    localparam int ADDR_W = 20;
    localparam int LAST   = 15;
    localparam int TMO    = 8;

    // ---------------- clock / reset ----------------
    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    always #5 i_clk = ~i_clk;

    // ---------------- main DUT ----------------
    logic              i_start = 1'b0;
    logic [7:0]        i_seed  = 8'h00;
    logic              i_ack   = 1'b0;
    logic [7:0]        i_rdata = 8'h00;
    logic              o_req, o_we, o_busy, o_done, o_pass, o_timeout, o_led;
    logic [ADDR_W-1:0] o_addr, o_fail_addr;
    logic [7:0]        o_wdata;
    logic [15:0]       o_err_cnt;
    logic [1:0]        dbg_state;

    sram_bist #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_seed(i_seed),
        .o_req(o_req), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_ack(i_ack), .i_rdata(i_rdata), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_timeout(o_timeout), .o_err_cnt(o_err_cnt),
        .o_fail_addr(o_fail_addr), .o_led(o_led), .dbg_state(dbg_state)
    );

    // ---------------- single-address DUT ----------------
    logic        z_start = 1'b0;
    logic [7:0]  z_seed  = 8'h00;
    logic        z_req, z_we, z_busy, z_done, z_pass, z_timeout, z_led, z_ack;
    logic [7:0]  z_addr, z_fail, z_wdata, z_rdata;
    logic [7:0]  z_mem = 8'h00;
    logic [15:0] z_err;
    logic [1:0]  z_state;
    int          z_nw, z_nr;

    assign z_ack   = z_req;
    assign z_rdata = z_mem;

    sram_bist #(.ADDR_W(8), .LAST_ADDR(0), .TIMEOUT(16)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(z_start), .i_seed(z_seed),
        .o_req(z_req), .o_we(z_we), .o_addr(z_addr), .o_wdata(z_wdata),
        .i_ack(z_ack), .i_rdata(z_rdata), .o_busy(z_busy), .o_done(z_done),
        .o_pass(z_pass), .o_timeout(z_timeout), .o_err_cnt(z_err),
        .o_fail_addr(z_fail), .o_led(z_led), .dbg_state(z_state)
    );

    always @(negedge i_clk) begin
        if (z_req) begin
            if (z_we) begin
                z_mem = z_wdata;
                z_nw++;
            end else begin
                z_nr++;
            end
        end
    end

    // ---------------- counters / compare helper ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int unsigned a, input logic [7:0] s);
        int unsigned v;
        v = (a % 256) ^ ((a / 256) % 256) ^ ((a / 65536) % 16);
        return 8'(v) ^ s;
    endfunction

    // ---------------- SRAM model / ack driver ----------------
    logic [7:0]  mem [0:15];
    logic [15:0] corrupt   = '0;
    int          hang_addr = -1;
    int          dly_min   = 0;
    int          dly_max   = 0;
    bit          gap_noise = 0;
    int          req_age   = 0;
    int          cur_dly   = 0;
    logic [7:0]  wd_at3    = 8'h00;

    always @(negedge i_clk) begin
        if (!o_req) begin
            req_age = 0;
            i_ack   = gap_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_rdata = 8'($urandom);
        end else begin
            if (req_age == 0) cur_dly = int'($urandom_range(dly_max, dly_min));
            if (req_age >= cur_dly && int'(o_addr) != hang_addr) begin
                i_ack = 1'b1;
                if (o_we) begin
                    mem[o_addr[3:0]] = o_wdata;
                    if (o_addr == 3) wd_at3 = o_wdata;
                end else begin
                    i_rdata = mem[o_addr[3:0]] ^ (corrupt[o_addr[3:0]] ? 8'h5A : 8'h00);
                end
            end else begin
                i_ack   = 1'b0;
                i_rdata = 8'($urandom);
            end
            req_age++;
        end
    end

    // ---------------- scoreboard: behavioural model + per-cycle compare ----------------
    // exp_q entry = {we, addr[19:0], data[7:0]} in the order the test must issue them.
    logic [28:0] exp_q[$];
    bit          chk_en = 0;
    bit          m_busy = 0, m_req = 0, m_done = 0, m_pass = 0, m_tmo = 0;
    int          m_err = 0, m_fail = 0, m_wait = 0;
    int          n_wr = 0, n_rd = 0;

    always @(negedge i_clk) begin
        logic [28:0] t;
        #1;
        if (chk_en) begin
            if (!i_rst_n) begin
                chk("rst_flags", {25'b0, o_req, o_we, o_busy, o_done, o_pass, o_timeout, o_led}, 32'd0);
                chk("rst_addr", o_addr, 32'd0);
                chk("rst_wdata", o_wdata, 32'd0);
                chk("rst_err_cnt", o_err_cnt, 32'd0);
                chk("rst_fail_addr", o_fail_addr, 32'd0);
                m_busy = 0; m_req = 0; m_done = 0; m_pass = 0; m_tmo = 0;
                m_err = 0; m_fail = 0; m_wait = 0;
                exp_q.delete();
            end else begin
                chk("busy", o_busy, m_busy);
                chk("req", o_req, m_req);
                chk("done", o_done, m_done);
                chk("timeout", o_timeout, m_tmo);
                chk("err_cnt", o_err_cnt, m_err);
                chk("fail_addr", o_fail_addr, m_fail);
                chk("led", o_led, (!m_busy && m_done && m_pass));
                if (m_done) chk("pass", o_pass, m_pass);
                if (m_req && exp_q.size() > 0) begin
                    t = exp_q[0];
                    chk("we", o_we, t[28]);
                    chk("addr", o_addr, t[27:8]);
                    if (t[28]) chk("wdata", o_wdata, t[7:0]);
                end

                // advance the model by one cycle
                if (m_busy) begin
                    if (m_req) begin
                        if (i_ack) begin
                            t = exp_q.pop_front();
                            if (t[28]) begin
                                n_wr++;
                            end else begin
                                n_rd++;
                                if (i_rdata !== t[7:0]) begin
                                    if (m_err == 0) m_fail = int'(t[27:8]);
                                    if (m_err < 65535) m_err++;
                                end
                            end
                            m_req = 0;
                            if (exp_q.size() == 0) begin
                                m_busy = 0; m_done = 1; m_pass = (m_err == 0);
                            end
                        end else begin
                            m_wait++;
                            if (m_wait == TMO) begin
                                m_busy = 0; m_req = 0; m_done = 1; m_tmo = 1; m_pass = 0;
                            end
                        end
                    end else begin
                        m_req  = 1;
                        m_wait = 0;
                    end
                end else if (i_start) begin
                    m_busy = 1; m_req = 1; m_wait = 0;
                    m_done = 0; m_pass = 0; m_tmo = 0; m_err = 0; m_fail = 0;
                    n_wr = 0; n_rd = 0;
                    exp_q.delete();
                    for (int a = 0; a <= LAST; a++) exp_q.push_back({1'b1, 20'(a), pat(a, i_seed)});
                    for (int a = 0; a <= LAST; a++) exp_q.push_back({1'b0, 20'(a), pat(a, i_seed)});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Pulse start and wait (bounded) for o_done; cycles counts from the
    // cycle after the start cycle, so done appearing N cycles after the
    // start cycle returns N.
    task automatic run_test(input logic [7:0] s, input bit poke, output int cycles);
        @(negedge i_clk);
        i_seed  = s;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        cycles  = 1;
        while (!o_done && cycles < 3000) begin
            if (poke && o_busy && $urandom_range(0, 5) == 0) begin
                i_start = 1'b1;
                i_seed  = 8'($urandom);
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
            cycles++;
        end
        i_start = 1'b0;
        if (!o_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_wait: got no o_done expected o_done within 3000 cycles at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // ---------------- test sequence ----------------
    int cyc;
    int k;

    initial begin
        #2 i_rst_n = 1'b0;
        chk_en = 1;
        idle(3);
        i_rst_n = 1'b1;
        idle(4);                       // no start: must stay idle

        // clean run, seed 0, single-cycle ack
        run_test(8'h00, 0, cyc);
        chk("a_cycles", cyc, 64);
        chk("a_writes", n_wr, 16);
        chk("a_reads", n_rd, 16);
        chk("a_pass", o_pass, 1);
        chk("a_err", o_err_cnt, 0);
        chk("a_led", o_led, 1);
        idle(2);

        // corrupted reads at 5 and 9
        corrupt = 16'h0220;
        run_test(8'h00, 0, cyc);
        chk("b_pass", o_pass, 0);
        chk("b_err", o_err_cnt, 2);
        chk("b_fail_addr", o_fail_addr, 5);
        chk("b_led", o_led, 0);
        corrupt = '0;
        idle(2);

        // ack delayed 3 cycles, seed A5
        dly_min = 3; dly_max = 3;
        run_test(8'hA5, 0, cyc);
        chk("c_wdata_at3", wd_at3, 8'hA6);
        chk("c_cycles", cyc, 160);
        chk("c_pass", o_pass, 1);
        dly_min = 0; dly_max = 0;
        idle(2);

        // address 2 never acknowledged
        hang_addr = 2;
        run_test(8'h3C, 0, cyc);
        chk("d_cycles", cyc, 13);
        chk("d_timeout", o_timeout, 1);
        chk("d_done", o_done, 1);
        chk("d_pass", o_pass, 0);
        chk("d_req", o_req, 0);
        hang_addr = -1;
        idle(2);

        // reset in the middle of the read pass, then a fresh test
        @(negedge i_clk);
        i_seed  = 8'($urandom);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        k = 0;
        while (!(o_busy && o_req && !o_we) && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        chk("e_reached_read", (o_busy && o_req && !o_we), 1);
        idle($urandom_range(0, 3));
        i_rst_n = 1'b0;
        idle(2);
        i_rst_n = 1'b1;
        idle(3);
        run_test(8'h5E, 0, cyc);
        chk("e_pass", o_pass, 1);
        chk("e_writes", n_wr, 16);
        chk("e_reads", n_rd, 16);
        idle(2);

        // start pulses while busy, stray acks in gap cycles, random delays
        gap_noise = 1; dly_min = 0; dly_max = 2;
        run_test(8'($urandom), 1, cyc);
        chk("f_pass", o_pass, 1);
        chk("f_writes", n_wr, 16);
        chk("f_reads", n_rd, 16);
        idle(2);

        // randomized runs
        for (int r = 0; r < 4; r++) begin
            corrupt   = 16'($urandom & $urandom & $urandom);
            dly_min   = 0;
            dly_max   = int'($urandom_range(0, 4));
            gap_noise = 1'($urandom_range(0, 1));
            run_test(8'($urandom), 1'($urandom_range(0, 1)), cyc);
            chk("r_err", o_err_cnt, $countones(corrupt));
            chk("r_pass", o_pass, (corrupt == 0));
            idle($urandom_range(1, 3));
        end
        corrupt = '0; gap_noise = 0; dly_max = 0;

        // single-address instance: one write then one read
        z_nw = 0; z_nr = 0;
        @(negedge i_clk);
        z_seed  = 8'($urandom);
        z_start = 1'b1;
        @(negedge i_clk);
        z_start = 1'b0;
        cyc = 1;
        while (!z_done && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("z_cycles", cyc, 4);
        chk("z_writes", z_nw, 1);
        chk("z_reads", z_nr, 1);
        chk("z_wdata", z_mem, z_seed);
        chk("z_pass", z_pass, 1);
        chk("z_busy", z_busy, 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bist.md
SRAM_BIST -- requirements
Module: sram_bist

Interface
REQ-001 Parameter ADDR_W, default 20, SHALL set address width (1Mx8 part).
REQ-002 Parameter LAST_ADDR, default 2**ADDR_W-1, SHALL set the final address tested; 0..LAST_ADDR inclusive.
REQ-003 Parameter TIMEOUT, default 1024, SHALL set the max cycles o_req may wait for i_ack.
REQ-004 i_clk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle start pulse.
REQ-007 i_seed  in  8  pattern seed, sampled on accepted start.
REQ-008 o_req  out  1  transaction request to SRAM controller.
REQ-009 o_we  out  1  1=write, 0=read; valid while o_req=1.
REQ-010 o_addr  out  ADDR_W  transaction address.
REQ-011 o_wdata  out  8  write data.
REQ-012 i_ack  in  1  controller completion strobe.
REQ-013 i_rdata  in  8  read data, valid only in the i_ack cycle of a read.
REQ-014 o_busy  out  1  test in progress.
REQ-015 o_done  out  1  test finished; held until next accepted start.
REQ-016 o_pass  out  1  valid when o_done=1; 1 = zero errors, no timeout.
REQ-017 o_timeout  out  1  test aborted by ack timeout.
REQ-018 o_err_cnt  out  16  mismatch count.
REQ-019 o_fail_addr  out  ADDR_W  address of first mismatch.
REQ-020 o_led  out  1  status indicator.

Function
REQ-021 Pattern SHALL be P(a) = a[7:0] ^ a[15:8] ^ {4'h0,a[19:16]} ^ seed (bits beyond ADDR_W read as 0).
REQ-022 States SHALL be IDLE, WRITE, READ, DONE.
REQ-023 IDLE/DONE: i_start=1 -> WRITE, address 0, seed latched, o_err_cnt, o_fail_addr, o_timeout, o_done, o_pass cleared.
REQ-024 i_start while o_busy=1 SHALL be ignored.
REQ-025 In WRITE/READ, o_req, o_we, o_addr, o_wdata SHALL be registered and held stable from o_req rise until the i_ack cycle.
REQ-026 Transaction completes in the cycle o_req=1 and i_ack=1; o_req SHALL be 0 the following cycle (one-cycle gap) and reassert the cycle after for the next transaction.
REQ-027 i_ack while o_req=0 SHALL be ignored.
REQ-028 WRITE: o_we=1, o_wdata=P(addr); on ack, address increments; on ack at LAST_ADDR -> READ, address 0.
REQ-029 READ: o_we=0; on ack, i_rdata compared to P(addr); mismatch increments o_err_cnt, saturating at 16'hFFFF.
REQ-030 First mismatch (o_err_cnt was 0) SHALL capture o_fail_addr; later mismatches SHALL not change it.
REQ-031 READ ack at LAST_ADDR -> DONE: o_done=1, o_pass = (final count==0), o_busy=0.
REQ-032 Wait counter SHALL clear at each o_req rise; if TIMEOUT cycles elapse with o_req=1 and no i_ack -> DONE, o_timeout=1, o_pass=0, o_req=0.
REQ-033 LAST_ADDR=0 SHALL yield exactly one write then one read.
REQ-034 o_busy=1 exactly in WRITE and READ.
REQ-035 o_led SHALL be 1 in DONE with pass, toggle every 2**22 cycles while busy, 0 otherwise (incl. DONE with fail).
REQ-036 Total cycles for a clean test with single-cycle ack SHALL be 4*(LAST_ADDR+1) from start to o_done (req cycle plus gap per transaction).

Reset
REQ-037 i_rst_n=0 SHALL immediately force IDLE and o_req=0, o_we=0, o_addr=0, o_wdata=0, o_busy=0, o_done=0, o_pass=0, o_timeout=0, o_err_cnt=0, o_fail_addr=0, o_led=0.
REQ-038 Reset mid-transaction SHALL abandon it; no resumption after release.
REQ-039 After release, first state change SHALL require a new i_start.

Verification
REQ-040 LAST_ADDR=15, seed 8'h00, ideal SRAM model with 1-cycle ack -> 16 writes, 16 reads, o_done at 64 cycles, o_pass=1, o_err_cnt=0, o_led=1.
REQ-041 Same, model corrupts read at addr 5 and 9 -> o_pass=0, o_err_cnt=2, o_fail_addr=5.
REQ-042 Model ack delayed 3 cycles, seed 8'hA5 -> o_addr/o_wdata stable through wait, o_wdata at addr 3 = 8'hA6, o_pass=1.
REQ-043 TIMEOUT=8, model never acks addr 2 -> o_timeout=1, o_done=1, o_pass=0, o_req=0 after 8 wait cycles.
REQ-044 Assert i_rst_n=0 mid-READ, then release and pulse i_start -> outputs at reset values, fresh test passes from address 0.
REQ-045 i_start pulsed during WRITE; i_ack pulsed during gap cycles -> no restart, no extra address advance.
